// File: rtl/red_pitaya_iq_demodulator_block_pkg.sv
// Shared constants and helpers for the IQ demodulator block.
//   Widths of the input, NCO and output words, product/accumulator widths,
//   output saturation limits, averaging-exponent clamp and window mask.
package red_pitaya_iq_demodulator_block_pkg;

  localparam int unsigned INBITS  = 14;
  localparam int unsigned SINBITS = 14;
  localparam int unsigned OUTBITS = 18;
  localparam int unsigned MAXLOG2 = 10;

  localparam int unsigned P       = INBITS + SINBITS;
  localparam int unsigned ACCW    = P + MAXLOG2;
  localparam int unsigned CNTW    = MAXLOG2;
  localparam int unsigned LOGW    = 4;
  // Lowest mean bit that lands in the output word.
  localparam int unsigned OUT_LSB = P - 1 - OUTBITS;

  localparam logic signed [OUTBITS-1:0] OUT_MAX = {1'b0, {(OUTBITS-1){1'b1}}};
  localparam logic signed [OUTBITS-1:0] OUT_MIN = {1'b1, {(OUTBITS-1){1'b0}}};

  // Stage-0 sample: signal, NCO pair and clear captured on one edge.
  typedef struct packed {
    logic signed [INBITS-1:0]  sig;
    logic signed [SINBITS-1:0] sin_v;
    logic signed [SINBITS-1:0] cos_v;
    logic                      clear;
  } sample_t;

  function automatic logic [LOGW-1:0] clamp_log2(input logic [LOGW-1:0] a);
    return (a > LOGW'(MAXLOG2)) ? LOGW'(MAXLOG2) : a;
  endfunction

  // Counter value of the last sample in a 2^n window.
  function automatic logic [CNTW-1:0] win_last(input logic [LOGW-1:0] n);
    return ~({CNTW{1'b1}} << n);
  endfunction

endpackage

// File: rtl/red_pitaya_iq_demod_accumulator.sv
// Per-quadrature boxcar: accumulate products, shift by the window exponent,
// saturate to the output width.
//   clk_i, rst_n : clock, internal async active-low reset
//   clear        : discard the running sum
//   first        : current product opens a window
//   load         : current product closes a window; update avg
//   shift        : window exponent N
//   prod         : signed product
//   avg          : registered averaged output (holds between loads)
//   sat_c        : combinational, mean of the closing window is out of range
module red_pitaya_iq_demod_accumulator
  import red_pitaya_iq_demodulator_block_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      first,
  input  logic                      load,
  input  logic [LOGW-1:0]           shift,
  input  logic signed [P-1:0]       prod,
  output logic signed [OUTBITS-1:0] avg,
  output logic                      sat_c
);

  logic signed [ACCW-1:0]    acc_q;
  logic signed [ACCW-1:0]    base_c;
  logic signed [ACCW-1:0]    sum_c;
  logic signed [OUTBITS:0]   top_c;
  logic signed [OUTBITS-1:0] avg_c;

  // Running sum, mean bits m[P-1:OUT_LSB] and saturation.
  always_comb begin
    base_c = first ? '0 : acc_q;
    sum_c  = base_c + ACCW'(prod);
    top_c  = (OUTBITS+1)'(sum_c >>> (32'(shift) + OUT_LSB));
    sat_c  = top_c[OUTBITS] ^ top_c[OUTBITS-1];
    if (sat_c) begin
      avg_c = top_c[OUTBITS] ? OUT_MIN : OUT_MAX;
    end else begin
      avg_c = top_c[OUTBITS-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      avg   <= '0;
    end else begin
      acc_q <= clear ? '0 : sum_c;
      if (load) begin
        avg <= avg_c;
      end
    end
  end

endmodule

// File: rtl/red_pitaya_iq_demodulator_block.sv
// IQ demodulator: mixes signal_i with the shared NCO sin/cos and averages each
// quadrature over a 2^avg_log2 decimating boxcar window.
//   clk_i, rstn_i           : clock, async active-low reset
//   sin, cos                : signed NCO outputs
//   signal_i                : signed input to demodulate
//   avg_log2                : window exponent (clamped to MAXLOG2)
//   clear_i                 : restart window, aborted window gives no strobe
//   signal_q1_o/signal_q2_o : averaged I (sig*sin) / Q (sig*cos)
//   valid_o, overflow_o     : one-cycle update strobe / saturation strobe
module red_pitaya_iq_demodulator_block
  import red_pitaya_iq_demodulator_block_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic signed [SINBITS-1:0] sin,
  input  logic signed [SINBITS-1:0] cos,
  input  logic signed [INBITS-1:0]  signal_i,
  input  logic [LOGW-1:0]           avg_log2,
  input  logic                      clear_i,
  output logic signed [OUTBITS-1:0] signal_q1_o,
  output logic signed [OUTBITS-1:0] signal_q2_o,
  output logic                      valid_o,
  output logic                      overflow_o
);

  logic [1:0]          rst_sync_q;
  logic                rst_n;
  sample_t             s0_q;
  logic signed [P-1:0] sig_x, sin_x, cos_x;
  logic signed [P-1:0] p1_q, p2_q;
  logic                clr_p_q;
  logic [CNTW-1:0]     cnt_q;
  logic [LOGW-1:0]     n_q, n_eff_c;
  logic                first_c, last_c, fire_c;
  logic                sat1_c, sat2_c;

  // Reset: asserted asynchronously, released on a registered edge.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end
  assign rst_n = rst_sync_q[1];

  // Stage 0/1: aligned sample capture, then products; clear rides along.
  always_comb begin
    sig_x = P'($signed(s0_q.sig));
    sin_x = P'($signed(s0_q.sin_v));
    cos_x = P'($signed(s0_q.cos_v));
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      s0_q    <= '0;
      p1_q    <= '0;
      p2_q    <= '0;
      clr_p_q <= 1'b0;
    end else begin
      s0_q    <= '{sig: signal_i, sin_v: sin, cos_v: cos, clear: clear_i};
      p1_q    <= sig_x * sin_x;
      p2_q    <= sig_x * cos_x;
      clr_p_q <= s0_q.clear;
    end
  end

  // Window control: N taken fresh at window start, held otherwise.
  always_comb begin
    first_c = (cnt_q == '0);
    n_eff_c = first_c ? clamp_log2(avg_log2) : n_q;
    last_c  = (cnt_q == win_last(n_eff_c));
    fire_c  = last_c & ~clr_p_q;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      n_q        <= '0;
      valid_o    <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      cnt_q      <= (clr_p_q || last_c) ? '0 : cnt_q + CNTW'(1);
      n_q        <= n_eff_c;
      valid_o    <= fire_c;
      overflow_o <= fire_c & (sat1_c | sat2_c);
    end
  end

  red_pitaya_iq_demod_accumulator u_acc_q1 (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .clear (clr_p_q),
    .first (first_c),
    .load  (fire_c),
    .shift (n_eff_c),
    .prod  (p1_q),
    .avg   (signal_q1_o),
    .sat_c (sat1_c)
  );

  red_pitaya_iq_demod_accumulator u_acc_q2 (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .clear (clr_p_q),
    .first (first_c),
    .load  (fire_c),
    .shift (n_eff_c),
    .prod  (p2_q),
    .avg   (signal_q2_o),
    .sat_c (sat2_c)
  );

endmodule

// File: tb/tb_red_pitaya_iq_demodulator_block.sv
// Directed bench for red_pitaya_iq_demodulator_block.
module tb_red_pitaya_iq_demodulator_block;

  logic               clk_i = 1'b0;
  logic               rstn_i;
  logic signed [13:0] sin, cos, signal_i;
  logic [3:0]         avg_log2;
  logic               clear_i;
  logic signed [17:0] signal_q1_o, signal_q2_o;
  logic               valid_o, overflow_o;

  int errors = 0;
  int checks = 0;
  int n;
  logic anyv;

  red_pitaya_iq_demodulator_block dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .sin         (sin),
    .cos         (cos),
    .signal_i    (signal_i),
    .avg_log2    (avg_log2),
    .clear_i     (clear_i),
    .signal_q1_o (signal_q1_o),
    .signal_q2_o (signal_q2_o),
    .valid_o     (valid_o),
    .overflow_o  (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk_i);
      @(negedge clk_i);
    end
  endtask

  // Cycles until the next valid_o strobe, -1 on timeout.
  task automatic wait_strobe(input int max, output int cyc);
    cyc = 0;
    do begin
      step(1);
      cyc++;
    end while (valid_o !== 1'b1 && cyc < max);
    if (valid_o !== 1'b1) cyc = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rstn_i = 1'b0; signal_i = '0; sin = '0; cos = '0;
    avg_log2 = 4'd0; clear_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_q1", signal_q1_o, 0);
    chk("rst_q2", signal_q2_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_ovf", overflow_o, 0);

    // N=0 basic mixing
    signal_i = 14'sd4096; sin = 14'sd8191; cos = 14'sd0;
    rstn_i = 1'b1;
    step(6);
    chk("n0_q1", signal_q1_o, 65528);
    chk("n0_q2", signal_q2_o, 0);
    chk("n0_valid", valid_o, 1);
    chk("n0_ovf", overflow_o, 0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("n0_valid_cont", valid_o, 1);
      chk("n0_q1_cont", signal_q1_o, 65528);
    end

    // N=0 latency and positive saturation
    signal_i = -14'sd8192; sin = -14'sd8192;
    step(2);
    chk("lat_hold_q1", signal_q1_o, 65528);
    step(1);
    chk("sat_q1", signal_q1_o, 131071);
    chk("sat_ovf", overflow_o, 1);
    chk("sat_valid", valid_o, 1);
    sin = 14'sd8191;
    step(3);
    chk("neg_q1", signal_q1_o, -131056);
    chk("neg_ovf", overflow_o, 0);

    // N=2 window aligned by a clear sample
    avg_log2 = 4'd2; clear_i = 1'b1; signal_i = '0;
    anyv = 1'b0;
    step(1); anyv |= valid_o;
    clear_i = 1'b0; signal_i = 14'sd4096; cos = 14'sd0;
    sin = 14'sd8191;  step(1); anyv |= valid_o;
    sin = -14'sd8191; step(1); anyv |= valid_o;
    sin = 14'sd8191;  step(1); anyv |= valid_o;
    step(1); anyv |= valid_o;
    signal_i = '0;
    step(1); anyv |= valid_o;
    chk("n2_no_early_valid", anyv, 0);
    step(1);
    chk("n2_valid", valid_o, 1);
    chk("n2_q1", signal_q1_o, 32764);
    chk("n2_q2", signal_q2_o, 0);
    chk("n2_ovf", overflow_o, 0);
    step(1);
    chk("n2_pulse", valid_o, 0);
    wait_strobe(16, n);
    chk("n2_period", n, 3);
    chk("n2_zero_q1", signal_q1_o, 0);

    // clear on the window's last sample wins
    signal_i = 14'sd8191; sin = 14'sd8191; cos = 14'sd8191;
    anyv = 1'b0;
    step(1); anyv |= valid_o;
    clear_i = 1'b1;
    step(1); anyv |= valid_o;
    clear_i = 1'b0; signal_i = 14'sd1024; sin = 14'sd8191; cos = 14'sd4096;
    for (int i = 0; i < 5; i++) begin
      step(1); anyv |= valid_o;
    end
    chk("clr_last_no_strobe", anyv, 0);
    step(1);
    chk("clr_last_valid", valid_o, 1);
    chk("clr_last_q1", signal_q1_o, 16382);
    chk("clr_last_q2", signal_q2_o, 8192);
    chk("clr_last_ovf", overflow_o, 0);

    // clear after two samples of a window
    clear_i = 1'b1; signal_i = 14'sd8191; sin = 14'sd8191; cos = 14'sd8191;
    anyv = 1'b0;
    step(1); anyv |= valid_o;
    clear_i = 1'b0; signal_i = -14'sd1024; sin = 14'sd8191; cos = -14'sd4096;
    for (int i = 0; i < 5; i++) begin
      step(1); anyv |= valid_o;
    end
    chk("clr_mid_no_strobe", anyv, 0);
    step(1);
    chk("clr_mid_valid", valid_o, 1);
    chk("clr_mid_q1", signal_q1_o, -16382);
    chk("clr_mid_q2", signal_q2_o, 8192);
    chk("clr_mid_ovf", overflow_o, 0);

    // avg_log2 2 -> 3 mid-window
    step(1);
    avg_log2 = 4'd3;
    wait_strobe(20, n);
    chk("log2_cur_window", n, 3);
    wait_strobe(20, n);
    chk("log2_next_window", n, 8);
    chk("log2_q1", signal_q1_o, -16382);

    // avg_log2 beyond MAXLOG2 clamps to 1024 samples
    step(1);
    avg_log2 = 4'd15;
    wait_strobe(20, n);
    chk("clamp_cur_window", n, 7);
    wait_strobe(1100, n);
    chk("clamp_period", n, 1024);
    chk("clamp_q1", signal_q1_o, -16382);

    // reset mid-window: immediate clear, full window after release
    avg_log2 = 4'd2;
    step(2);
    chk("pre_rst_q1", signal_q1_o, -16382);
    #2 rstn_i = 1'b0;
    #1;
    chk("async_rst_q1", signal_q1_o, 0);
    chk("async_rst_q2", signal_q2_o, 0);
    chk("async_rst_valid", valid_o, 0);
    chk("async_rst_ovf", overflow_o, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    rstn_i = 1'b1;
    wait_strobe(20, n);
    chk("post_rst_first", n, 6);
    wait_strobe(20, n);
    chk("post_rst_period", n, 4);
    chk("post_rst_q1", signal_q1_o, -16382);
    chk("post_rst_q2", signal_q2_o, 8192);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/red_pitaya_iq_demodulator_block.md
# red_pitaya_iq_demodulator_block

Receive-side counterpart of the IQ modulator: mixes one ADC-domain input with the shared NCO sine and cosine, then produces the I and Q quadratures. Each quadrature is averaged over a programmable power-of-two window (boxcar, decimating) and saturated to the output width. The block sits between the input multiplexer and the IQ filter/scope taps, sharing the NCO with the modulator.

## Interface
- INBITS, 14, signed input signal width
- SINBITS, 14, signed sin/cos width
- OUTBITS, 18, signed quadrature output width (must be ≤ INBITS+SINBITS-1)
- MAXLOG2, 10, largest averaging exponent; accumulator width = INBITS+SINBITS+MAXLOG2
---
- clk_i  in  1  system clock; one clock domain
- rstn_i  in  1  reset, asynchronous, active-low
- sin  in  SINBITS  signed NCO sine
- cos  in  SINBITS  signed NCO cosine
- signal_i  in  INBITS  signed signal to demodulate
- avg_log2  in  4  window length = 2^avg_log2 samples; values > MAXLOG2 are treated as MAXLOG2
- clear_i  in  1  synchronous window restart, discards partial sums
- signal_q1_o  out  OUTBITS  I quadrature (signal·sin), averaged
- signal_q2_o  out  OUTBITS  Q quadrature (signal·cos), averaged
- valid_o  out  1  one-cycle strobe, outputs updated this cycle
- overflow_o  out  1  one-cycle strobe with valid_o when either quadrature saturated

## Operation
- Stage 0: register signal_i, sin and cos together on the same edge, so alignment is guaranteed.
- Stage 1: products p1 = sig·sin and p2 = sig·cos, each P = INBITS+SINBITS bits, registered.
- Stage 2, accumulator per quadrature, with window counter cnt in 0..2^N-1:
  - N is latched from avg_log2 (clamped) when cnt==0; changes mid-window apply to the next window.
  - sum = (cnt==0 ? 0 : acc) + p; acc <= sum; cnt increments and wraps at 2^N-1.
  - When cnt==2^N-1: m = sum >>> N (arithmetic, truncation). Output <= m[P-2:P-1-OUTBITS].
  - Saturation: if m[P-1] != m[P-2], output is +2^(OUTBITS-1)-1 or -2^(OUTBITS-1) by the sign of m, and overflow_o is asserted.
  - valid_o is registered alongside the outputs.
- N=0: every sample is a window; valid_o is high continuously.
- clear_i: cnt <= 0, acc discarded, N re-latched on the next sample. No valid_o is produced from the aborted window. Outputs hold their last value.
- Outputs hold between strobes.

## Timing
- Reset (async assert): all pipeline registers, acc, cnt, N, signal_q1_o, signal_q2_o, valid_o and overflow_o are 0. Deassertion is registered internally before use.
- Latency: a sample present before edge k is in stage 0 after k, the product register after k+1, and the output after k+2. For N=0, the output is visible 3 cycles after input.
- For N>0: valid_o rises 2 edges after the edge that captured the window's last sample. The strobe period is exactly 2^N cycles.
- clear_i on the same cycle as the window's last sample: clear wins; no strobe.
- Reset mid-window: partial sum lost. The first strobe comes a full window after release.

## Structure
- Shared package/header: width constants (P, accumulator width), saturation limits (max/min OUTBITS values), and the MAXLOG2 clamp.
- Sub-module red_pitaya_iq_demod_accumulator (per quadrature): accumulate, shift, saturate.
- Top level owns the input/product pipeline, counter, N latch and valid/overflow.

## Test plan
- N=0, signal_i=4096, sin=8191, cos=0 -> signal_q1_o=65528 and signal_q2_o=0 from cycle 3 on; valid_o constant 1.
- N=0, signal_i=-8192, sin=-8192 -> signal_q1_o=131071 with overflow_o=1. Then sin=8191 -> -131056 with overflow_o=0.
- N=2, signal_i=4096, sin sequence 8191,-8191,8191,8191 -> signal_q1_o=32764. valid_o pulses once per 4 cycles.
- N=2, clear_i after 2 samples -> no strobe for that window; the next strobe comes 4 samples after clear, containing only post-clear data.
- avg_log2 changed 2→3 mid-window -> current window ends at 4, the next at 8. avg_log2=15 -> strobe period 1024.
- rstn_i pulsed low mid-window -> all outputs 0 immediately, with no clock edge needed; the first strobe comes a full window after release.
